idex_skid_reg: RTL

//  Parametrised, elastic ID->EX pipeline register: next generation of the fixed ID/EX latch.

---
 rtl/idex_skid_reg.sv | 120 ++++++++++++
 1 files changed

// File: rtl/idex_skid_reg.sv
// Elastic ID->EX pipeline register with a 2-entry skid buffer, flush-to-bubble and control gating.
// Optional macro IDEX_PERF_CNT_EN adds saturating stall_cnt/bubble_cnt performance counters.
module idex_skid_reg #(
  parameter int DW = 8,
  parameter int IW = 32,
  parameter int PW = 32,
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [IW-1:0] id_instr,
  input  logic [PW-1:0] id_pc4,
  input  logic [CW-1:0] id_ctrl,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [DW-1:0] ex_rd1,
  output logic [DW-1:0] ex_rd2,
  output logic [IW-1:0] ex_instr,
  output logic [PW-1:0] ex_pc4,
  output logic [CW-1:0] ex_ctrl
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   bubble_cnt
`endif
);

  localparam int LW = 2*DW + IW + PW + CW;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] main_q, main_d;
  logic [LW-1:0] skid_q, skid_d;
  logic [LW-1:0] in_word;
  logic [CW-1:0] ctrl_q;
  logic          accept;
  logic          consume;

  assign in_word  = {id_rd1, id_rd2, id_instr, id_pc4, id_ctrl};
  // Both handshake flags come straight from the state register, so ex_ready never reaches id_ready combinationally.
  assign ex_valid = (state_q != EMPTY);
  assign id_ready = (state_q != FULL);
  assign accept   = id_valid & id_ready;
  assign consume  = ex_valid & ex_ready;

  assign {ex_rd1, ex_rd2, ex_instr, ex_pc4, ctrl_q} = main_q;
  assign ex_ctrl = ctrl_q & {CW{ex_valid}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_word;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_word;
          end else if (accept) begin
            skid_d  = in_word;
            state_d = FULL;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef IDEX_PERF_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (ex_valid && !ex_ready && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (!ex_valid && (bubble_q != 16'hFFFF)) bubble_q <= bubble_q + 16'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule
